// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace symbols into 30-bit frames for the OCI monitor and sequences end of test.
// Optional idle auto-flush is enabled by defining OCI_DCT_TIMEOUT_EN.
module nios2_oci_dct_packer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        sym_valid_i,
    input  logic [1:0]  sym_data_i,
    output logic        sym_ready_o,
    input  logic        flush_i,
    input  logic        end_req_i,
    output logic [29:0] dct_buffer_o,
    output logic [3:0]  dct_count_o,
    output logic        dct_valid_o,
    input  logic        dct_ready_i,
    output logic        test_ending_o,
    output logic        test_has_ended_o
);

    typedef enum logic [1:0] {S_RUN, S_ENDING, S_ENDED} state_t;

    state_t      state_q, state_d;
    logic [29:0] acc_q, acc_d;
    logic [3:0]  acc_cnt_q, acc_cnt_d;
    logic [29:0] out_buf_q, out_buf_d;
    logic [3:0]  out_cnt_q, out_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        flush_pend_q, flush_pend_d;

    logic        out_free, acc_full, accept, flush_any, transfer, timeout_hit;
    logic [29:0] sym_shift, merged_buf;
    logic [3:0]  merged_cnt;

    assign out_free    = !out_valid_q || dct_ready_i;
    assign acc_full    = (acc_cnt_q == 4'd15);
    assign sym_ready_o = (state_q == S_RUN) && !(acc_full && !out_free);
    assign accept      = sym_valid_i && sym_ready_o;
    assign sym_shift   = {28'b0, sym_data_i} << {acc_cnt_q, 1'b0};

    // A full accumulator is shipped as-is; the incoming symbol starts the next frame.
    assign merged_buf = acc_full ? acc_q : (accept ? (acc_q | sym_shift) : acc_q);
    assign merged_cnt = acc_full ? 4'd15 : (acc_cnt_q + {3'b0, accept});

    assign flush_any = flush_pend_q || flush_i || timeout_hit ||
                       ((state_q == S_RUN) && end_req_i);
    assign transfer  = out_free && ((merged_cnt == 4'd15) ||
                                    (flush_any && (merged_cnt != 4'd0)));

`ifdef OCI_DCT_TIMEOUT_EN
    logic [9:0] idle_q, idle_d;

    assign timeout_hit = (idle_q == TIMEOUT[9:0]);

    always_comb begin
        idle_d = idle_q;
        if (accept || transfer)
            idle_d = 10'd0;
        else if ((acc_cnt_q != 4'd0) && !timeout_hit)
            idle_d = idle_q + 10'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) idle_q <= 10'd0;
        else         idle_q <= idle_d;
    end
`else
    // TIMEOUT is only meaningful with the idle counter; its legal range makes this false.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_comb begin
        acc_d        = merged_buf;
        acc_cnt_d    = merged_cnt;
        out_buf_d    = out_buf_q;
        out_cnt_d    = out_cnt_q;
        out_valid_d  = out_valid_q && !dct_ready_i;
        flush_pend_d = flush_any && !transfer && (merged_cnt != 4'd0);
        if (transfer) begin
            out_buf_d   = merged_buf;
            out_cnt_d   = merged_cnt;
            out_valid_d = 1'b1;
            acc_d       = (acc_full && accept) ? {28'b0, sym_data_i} : 30'b0;
            acc_cnt_d   = (acc_full && accept) ? 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (end_req_i)
                    state_d = ((merged_cnt == 4'd0) && out_free) ? S_ENDED : S_ENDING;
            end
            S_ENDING: begin
                if ((acc_cnt_q == 4'd0) && out_free)
                    state_d = S_ENDED;
            end
            S_ENDED:  state_d = S_ENDED;
            default:  state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_RUN;
            acc_q        <= 30'b0;
            acc_cnt_q    <= 4'd0;
            out_buf_q    <= 30'b0;
            out_cnt_q    <= 4'd0;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            out_buf_q    <= out_buf_d;
            out_cnt_q    <= out_cnt_d;
            out_valid_q  <= out_valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign dct_buffer_o     = out_buf_q;
    assign dct_count_o      = out_cnt_q;
    assign dct_valid_o      = out_valid_q;
    assign test_ending_o    = (state_q != S_RUN);
    assign test_has_ended_o = (state_q == S_ENDED);

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Scoreboard bench for nios2_oci_dct_packer: stimulus pushes expected frames, a monitor pops them.
module tb_nios2_oci_dct_packer;

`ifdef OCI_DCT_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sym_valid = 1'b0;
    logic [1:0]  sym_data = 2'd0;
    logic        sym_ready;
    logic        flush = 1'b0;
    logic        end_req = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready = 1'b1;
    logic        test_ending;
    logic        test_has_ended;

    int n_checks = 0;
    int n_fail   = 0;
    logic [33:0] exp_q[$];
    logic        hold = 1'b0;
    logic [33:0] held = '0;

    nios2_oci_dct_packer #(.TIMEOUT(TMO)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .sym_valid_i      (sym_valid),
        .sym_data_i       (sym_data),
        .sym_ready_o      (sym_ready),
        .flush_i          (flush),
        .end_req_i        (end_req),
        .dct_buffer_o     (dct_buffer),
        .dct_count_o      (dct_count),
        .dct_valid_o      (dct_valid),
        .dct_ready_i      (dct_ready),
        .test_ending_o    (test_ending),
        .test_has_ended_o (test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks held frames stay stable.
    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold && dct_valid)
                chk("held_frame_stable", {30'b0, dct_count, dct_buffer}, {30'b0, held});
            if (dct_valid && dct_ready) begin
                if (exp_q.size() == 0)
                    chk("unexpected_frame", {30'b0, dct_count, dct_buffer}, 64'h0);
                else
                    chk("frame", {30'b0, dct_count, dct_buffer}, {30'b0, exp_q.pop_front()});
            end
            hold = dct_valid && !dct_ready;
            held = {dct_count, dct_buffer};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [1:0] d, output logic ok);
        sym_valid = 1'b1;
        sym_data  = d;
        @(negedge clk);
        ok = sym_ready;
        step();
        sym_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [1:0] base, input bit ramp);
        logic ok;
        for (int i = 0; i < n; i++) begin
            send_sym(ramp ? 2'(base + 2'(i)) : base, ok);
            if (!ok) chk("sym_accepted", 64'(ok), 64'd1);
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        sym_valid = 1'b0; flush = 1'b0; end_req = 1'b0;
        step();
        exp_q.delete();
        reset = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_buffer"},    64'(dct_buffer),     64'd0);
        chk({tag, "_count"},     64'(dct_count),      64'd0);
        chk({tag, "_valid"},     64'(dct_valid),      64'd0);
        chk({tag, "_sym_ready"}, 64'(sym_ready),      64'd1);
        chk({tag, "_ending"},    64'(test_ending),    64'd0);
        chk({tag, "_ended"},     64'(test_has_ended), 64'd0);
    endtask

    initial begin
        logic ok;
        int   acc_n;
        int   n;
        bit   found;

        #3;
        check_reset_outputs("reset");
        step();
        reset = 1'b0;
        step();

        // Full frame of ramping symbols, valid one cycle after the 15th.
        dct_ready = 1'b1;
        exp_q.push_back({4'd15, 30'h24E4E4E4});
        send_n(14, 2'd0, 1'b1);
        send_sym(2'd2, ok);
        @(negedge clk);
        chk("full_frame_latency", 64'(dct_valid), 64'd1);
        drain();

        // Partial frame via flush; flush on empty accumulator emits nothing.
        send_n(5, 2'd3, 1'b0);
        exp_q.push_back({4'd5, 30'h3FF});
        pulse_flush();
        @(negedge clk);
        chk("flush_latency", 64'(dct_valid), 64'd1);
        drain();
        pulse_flush();
        repeat (3) step();
        @(negedge clk);
        chk("empty_flush_no_frame", 64'(dct_valid), 64'd0);
        step();

        // Back-pressure: 31 offered, 30 accepted, two frames held then released.
        dct_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 31; i++) begin
            send_sym(2'(i % 4), ok);
            if (ok) acc_n++;
            if (i == 30) chk("sym_ready_31st", 64'(ok), 64'd0);
        end
        chk("accepted_count", 64'(acc_n), 64'd30);
        exp_q.push_back({4'd15, 30'h24E4E4E4});
        exp_q.push_back({4'd15, 30'h13939393});
        repeat (3) step();
        dct_ready = 1'b1;
        drain();

        // End of test with 7 pending symbols.
        send_n(7, 2'd1, 1'b0);
        exp_q.push_back({4'd7, 30'h1555});
        end_req = 1'b1;
        step();
        end_req = 1'b0;
        @(negedge clk);
        chk("ending_next_cycle", 64'(test_ending), 64'd1);
        chk("ending_sym_ready",  64'(sym_ready),   64'd0);
        chk("ended_not_yet",     64'(test_has_ended), 64'd0);
        chk("end_frame_valid",   64'(dct_valid),   64'd1);
        step();
        @(negedge clk);
        chk("ended_after_handshake", 64'(test_has_ended), 64'd1);
        sym_valid = 1'b1;
        sym_data  = 2'd2;
        repeat (4) step();
        @(negedge clk);
        chk("ended_sym_ready", 64'(sym_ready), 64'd0);
        chk("ended_no_frame",  64'(dct_valid), 64'd0);
        chk("ended_sticky",    64'(test_has_ended), 64'd1);
        apply_reset();

        // end_req with nothing pending ends the next cycle.
        end_req = 1'b1;
        step();
        end_req = 1'b0;
        @(negedge clk);
        chk("ended_immediate", 64'(test_has_ended), 64'd1);
        apply_reset();

        // Reset mid-frame with a held frame and 9 symbols in the accumulator.
        dct_ready = 1'b0;
        send_n(15, 2'd2, 1'b0);
        send_n(9, 2'd1, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        step();
        reset = 1'b0;
        dct_ready = 1'b1;
        step();
        pulse_flush();
        repeat (4) step();
        @(negedge clk);
        chk("no_stale_frame", 64'(dct_valid), 64'd0);
        step();

        // Idle timeout behaviour.
        send_sym(2'd2, ok);
        send_sym(2'd1, ok);
        send_sym(2'd3, ok);
`ifdef OCI_DCT_TIMEOUT_EN
        exp_q.push_back({4'd3, 30'h36});
`endif
        n = 1;
        found = 1'b0;
        while (!found && n <= 100) begin
            @(negedge clk);
            if (dct_valid) found = 1'b1;
            else n++;
        end
        #1;
`ifdef OCI_DCT_TIMEOUT_EN
        chk("timeout_frame_seen", 64'(found), 64'd1);
        chk("timeout_window", 64'((n >= 8) && (n <= 10)), 64'd1);
        drain();
`else
        chk("no_timeout_frame", 64'(found), 64'd0);
        @(posedge clk);
        #1;
        exp_q.push_back({4'd3, 30'h36});
        pulse_flush();
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
